// File: rtl/comb_sweep_checker_pkg.sv
// Shared constants and result record for the 4-input combinational sweep checker.
package comb_sweep_checker_pkg;
  localparam int          VEC_W      = 4;
  localparam int          NUM_IMPL   = 4;
  localparam logic [15:0] COMB_TRUTH = 16'h6996;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic [4:0]          err_count;
    logic                first_fail_valid;
    logic [VEC_W-1:0]    first_fail_vec;
    logic [NUM_IMPL-1:0] fail_mask;
    logic                pass;
  } result_t;
endpackage

// File: rtl/comb_compare.sv
// Per-implementation mismatch against the golden truth table for the current vector.
module comb_compare
  import comb_sweep_checker_pkg::*;
(
  input  logic                str,
  input  logic                dataflow,
  input  logic                behavior,
  input  logic                prim,
  input  logic [VEC_W-1:0]    dcba,
  input  logic [15:0]         truth,
  output logic [NUM_IMPL-1:0] mm
);
  logic [NUM_IMPL-1:0] outs;
  assign outs = {prim, behavior, dataflow, str};

  for (genvar k = 0; k < NUM_IMPL; k++) begin : g_mm
    assign mm[k] = outs[k] ^ truth[dcba];
  end
endmodule

// File: rtl/comb_sweep_checker.sv
// Clocked sweep of DCBA 0..15 with hold windows; compares four implementations per vector.
module comb_sweep_checker
  import comb_sweep_checker_pkg::*;
#(
  parameter int          HOLD_CYCLES = 5,
  parameter logic [15:0] TRUTH       = COMB_TRUTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                str,
  input  logic                dataflow,
  input  logic                behavior,
  input  logic                prim,
  output logic [VEC_W-1:0]    dcba,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [4:0]          err_count,
  output logic                first_fail_valid,
  output logic [VEC_W-1:0]    first_fail_vec,
  output logic [NUM_IMPL-1:0] fail_mask
);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0]          state;
  logic [7:0]          hold_cnt;
  logic [NUM_IMPL-1:0] mm;
  logic                any_mm;
  logic [4:0]          err_next;
  result_t             res;

  comb_compare u_cmp (
    .str      (str),
    .dataflow (dataflow),
    .behavior (behavior),
    .prim     (prim),
    .dcba     (dcba),
    .truth    (TRUTH),
    .mm       (mm)
  );

  assign any_mm   = |mm;
  assign err_next = res.err_count + {4'd0, any_mm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      dcba     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_DRIVE;
          hold_cnt <= '0;
          dcba     <= '0;
          busy     <= 1'b1;
          res      <= '0;
        end
        ST_DRIVE: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt      <= '0;
            res.err_count <= err_next;
            if (any_mm && !res.first_fail_valid) begin
              res.first_fail_valid <= 1'b1;
              res.first_fail_vec   <= dcba;
              res.fail_mask        <= mm;
            end
            if (dcba == 4'd15) begin
              state    <= ST_DONE;
              dcba     <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              res.pass <= (err_next == 5'd0);
            end else begin
              dcba <= dcba + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pass             = res.pass;
  assign err_count        = res.err_count;
  assign first_fail_valid = res.first_fail_valid;
  assign first_fail_vec   = res.first_fail_vec;
  assign fail_mask        = res.fail_mask;
endmodule

// File: tb/tb_comb_sweep_checker.sv
// Randomized fault-injection bench: two checkers (H=5, H=1) against a vector-level reference model.
module tb_comb_sweep_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  start_s;
  logic [3:0]  out_s   [2];
  logic [3:0]  dcba_s  [2];
  logic [1:0]  busy_s, done_s, pass_s, ffv_s;
  logic [4:0]  err_s   [2];
  logic [3:0]  ffvec_s [2];
  logic [3:0]  fmask_s [2];
  logic [15:0] flt     [2][4];

  int total = 0;
  int bad   = 0;

  // Each implementation is the parity function with an injected per-vector fault mask.
  for (genvar i = 0; i < 2; i++) begin : g_env
    for (genvar k = 0; k < 4; k++) begin : g_impl
      always_comb out_s[i][k] = (^dcba_s[i]) ^ flt[i][k][dcba_s[i]];
    end
  end

  comb_sweep_checker #(.HOLD_CYCLES(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .str(out_s[0][0]), .dataflow(out_s[0][1]), .behavior(out_s[0][2]), .prim(out_s[0][3]),
    .dcba(dcba_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err_s[0]), .first_fail_valid(ffv_s[0]), .first_fail_vec(ffvec_s[0]),
    .fail_mask(fmask_s[0]));

  comb_sweep_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .str(out_s[1][0]), .dataflow(out_s[1][1]), .behavior(out_s[1][2]), .prim(out_s[1][3]),
    .dcba(dcba_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err_s[1]), .first_fail_valid(ffv_s[1]), .first_fail_vec(ffvec_s[1]),
    .fail_mask(fmask_s[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_results(input int i, input string tag, input int e_err, input bit e_ffv,
                             input int e_vec, input int e_mask, input bit e_pass);
    chk($sformatf("%s[%0d].err", tag, i),   err_s[i],   e_err);
    chk($sformatf("%s[%0d].ffv", tag, i),   ffv_s[i],   e_ffv);
    chk($sformatf("%s[%0d].ffvec", tag, i), ffvec_s[i], e_vec);
    chk($sformatf("%s[%0d].fmask", tag, i), fmask_s[i], e_mask);
    chk($sformatf("%s[%0d].pass", tag, i),  pass_s[i],  e_pass);
  endtask

  task automatic chk_all_zero(input int i, input string tag);
    chk($sformatf("%s[%0d].dcba", tag, i), dcba_s[i], 0);
    chk($sformatf("%s[%0d].busy", tag, i), busy_s[i], 0);
    chk($sformatf("%s[%0d].done", tag, i), done_s[i], 0);
    chk_results(i, tag, 0, 0, 0, 0, 0);
  endtask

  // Starts a sweep on instance i, follows it cycle by cycle and checks the final report.
  task automatic run_sweep(input int i, input int h, input bit restart_mid, input string tag);
    int e_err = 0, e_vec = 0, e_mask = 0;
    bit e_ffv = 0;
    for (int v = 0; v < 16; v++) begin
      int m = 0;
      for (int k = 0; k < 4; k++) if (flt[i][k][v]) m |= (1 << k);
      if (m != 0) begin
        e_err++;
        if (!e_ffv) begin e_ffv = 1; e_vec = v; e_mask = m; end
      end
    end
    @(negedge clk) start_s[i] = 1'b1;
    @(negedge clk) start_s[i] = 1'b0;
    for (int j = 0; j < 16 * h; j++) begin
      chk($sformatf("%s[%0d].dcba@%0d", tag, i, j), dcba_s[i], j / h);
      chk($sformatf("%s[%0d].busy@%0d", tag, i, j), busy_s[i], 1);
      chk($sformatf("%s[%0d].done@%0d", tag, i, j), done_s[i], 0);
      if (restart_mid && j == 20) start_s[i] = 1'b1;
      if (restart_mid && j == 21) start_s[i] = 1'b0;
      @(negedge clk);
    end
    start_s[i] = 1'b0;
    chk($sformatf("%s[%0d].done_end", tag, i), done_s[i], 1);
    chk($sformatf("%s[%0d].busy_end", tag, i), busy_s[i], 0);
    chk($sformatf("%s[%0d].dcba_end", tag, i), dcba_s[i], 0);
    chk_results(i, tag, e_err, e_ffv, e_vec, e_mask, e_err == 0);
    repeat (3) @(negedge clk);
    chk($sformatf("%s[%0d].done_idle", tag, i), done_s[i], 0);
    chk($sformatf("%s[%0d].busy_idle", tag, i), busy_s[i], 0);
    chk_results(i, {tag, "_hold"}, e_err, e_ffv, e_vec, e_mask, e_err == 0);
  endtask

  task automatic set_faults(input int i, input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3);
    flt[i][0] = f0; flt[i][1] = f1; flt[i][2] = f2; flt[i][3] = f3;
  endtask

  initial begin
    start_s = '0;
    for (int i = 0; i < 2; i++) set_faults(i, 0, 0, 0, 0);
    #12;
    for (int i = 0; i < 2; i++) chk_all_zero(i, "reset");
    @(negedge clk) rst_n = 1'b1;

    run_sweep(0, 5, 0, "clean5");
    run_sweep(1, 1, 0, "clean1");

    set_faults(0, 16'h6996, 0, 0, 0);
    run_sweep(0, 5, 0, "str_tied0");

    set_faults(0, 0, 0, 0, 16'h0400);
    run_sweep(0, 5, 0, "prim_inv10");

    set_faults(0, 0, 0, 0, 0);
    run_sweep(0, 5, 1, "restart_ignored");

    // Abort mid-sweep with faults active so the cleared counts are meaningful.
    set_faults(0, 16'h00ff, 0, 0, 0);
    @(negedge clk) start_s[0] = 1'b1;
    @(negedge clk) start_s[0] = 1'b0;
    for (int n = 0; n < 200 && dcba_s[0] != 4'd7; n++) @(negedge clk);
    chk("abort.reached7", dcba_s[0], 7);
    chk("abort.err_before", err_s[0], 7);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk_all_zero(i, "abort");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort.idle_dcba", dcba_s[0], 0);
    chk("abort.idle_busy", busy_s[0], 0);
    run_sweep(0, 5, 0, "after_abort");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] f [4];
        for (int k = 0; k < 4; k++)
          f[k] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
        set_faults(i, f[0], f[1], f[2], f[3]);
      end
      run_sweep(0, 5, 0, $sformatf("rand%0d", r));
      run_sweep(1, 1, 0, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
